// File: rtl/operand_pkg.sv
// Shared types for the operand pair loader and its neighbours.
package operand_pkg;
    localparam int OPERAND_W = 64;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HAVE_A = 2'd1,
        PAIR   = 2'd2
    } state_t;

    typedef struct packed {
        logic [OPERAND_W-1:0] a;
        logic [OPERAND_W-1:0] b;
    } pair_t;
endpackage

// File: rtl/operand_pair_loader_props.sv
// Checker bound into operand_pair_loader: held-pair stability, counter monotonicity.
module operand_pair_loader_props #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input logic             clock,
    input logic             reset_n,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] out_a,
    input logic [WIDTH-1:0] out_b,
    input logic [CNT_W-1:0] pair_count,
    input logic             odd_err
);
    logic             r_hold;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_odd;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_odd  <= 1'b0;
        end else begin
            r_hold <= out_valid & ~out_ready;
            r_a    <= out_a;
            r_b    <= out_b;
            r_cnt  <= pair_count;
            r_odd  <= odd_err;
        end
    end

    // Sampled values here are pre-update, so r_* is exactly one cycle older.
    always @(posedge clock) begin
        if (reset_n && r_hold) begin
            assert (out_a == r_a && out_b == r_b);
        end
        if (reset_n) begin
            assert (pair_count >= r_cnt);
        end
    end

    cover property (@(posedge clock) disable iff (!reset_n) odd_err && !r_odd);
endmodule

bind operand_pair_loader operand_pair_loader_props #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
) u_props (
    .clock     (clock),
    .reset_n   (reset_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .pair_count(pair_count),
    .odd_err   (odd_err)
);

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign count = r_count;
endmodule

// File: rtl/operand_pair_loader.sv
// Packs a 64-bit word stream into (a, b) operand pairs behind a valid/ready output.
module operand_pair_loader
    import operand_pkg::*;
#(
    parameter int WIDTH = OPERAND_W,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [CNT_W-1:0] pair_count,
    output logic             odd_err
);
    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_odd;
    logic             w_in_fire;
    logic             w_out_fire;

    // In PAIR the slot frees only as the consumer takes it, so ready passes through.
    assign in_ready   = !flush && ((r_state == PAIR) ? out_ready : 1'b1);
    assign out_valid  = !flush && (r_state == PAIR);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= EMPTY;
            r_a     <= '0;
            r_b     <= '0;
            r_odd   <= 1'b0;
        end else if (flush) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        if (in_last) begin
                            r_odd <= 1'b1;
                        end else begin
                            r_a     <= in_data;
                            r_state <= HAVE_A;
                        end
                    end
                end
                HAVE_A: begin
                    if (w_in_fire) begin
                        r_b     <= in_data;
                        r_state <= PAIR;
                    end
                end
                PAIR: begin
                    if (w_out_fire) begin
                        if (w_in_fire && !in_last) begin
                            r_a     <= in_data;
                            r_state <= HAVE_A;
                        end else begin
                            if (w_in_fire) r_odd <= 1'b1;
                            r_state <= EMPTY;
                        end
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_pair_cnt (
        .clock  (clock),
        .reset_n(reset_n),
        .inc    (w_out_fire),
        .count  (pair_count)
    );

    assign out_a   = r_a;
    assign out_b   = r_b;
    assign odd_err = r_odd;
endmodule

// File: tb/tb_operand_pair_loader.sv
// Scoreboard bench for operand_pair_loader; a CNT_W=2 twin shares the inputs.
module tb_operand_pair_loader;
    import operand_pkg::*;

    localparam int W = 64;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, odd_err;
    logic [W-1:0] out_a, out_b;
    logic [15:0]  pair_count;
    logic         s_in_ready, s_out_valid, s_odd_err;
    logic [W-1:0] s_out_a, s_out_b;
    logic [1:0]   s_pair_count;

    int vectors = 0;
    int miscompares = 0;
    int delivered = 0;
    int cyc = 0;

    pair_t sb[$];
    logic         m_have_a = 1'b0;
    logic [W-1:0] m_a = '0;
    int           m_cnt = 0;
    logic         m_odd = 1'b0;

    operand_pair_loader #(.WIDTH(W), .CNT_W(16)) u_dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .pair_count(pair_count), .odd_err(odd_err)
    );

    operand_pair_loader #(.WIDTH(W), .CNT_W(2)) u_dut_sat (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_a(s_out_a), .out_b(s_out_b),
        .pair_count(s_pair_count), .odd_err(s_odd_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Reference model: checks every cycle, then advances on the handshakes it predicts.
    always @(negedge clock) begin
        logic  e_valid, e_ready;
        logic [1:0] e_sat;
        pair_t exp_p;
        if (!reset_n) begin
            sb.delete();
            m_have_a = 1'b0;
            m_cnt    = 0;
            m_odd    = 1'b0;
        end else begin
            e_valid = (sb.size() > 0) && !flush;
            e_ready = flush ? 1'b0 : ((sb.size() > 0) ? out_ready : 1'b1);
            e_sat   = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
            vectors++;
            if (out_valid !== e_valid || s_out_valid !== e_valid) begin
                miscompares++;
                $display("FAIL mon_out_valid t=%0t got %b/%b want %b", $time, out_valid, s_out_valid, e_valid);
            end
            if (in_ready !== e_ready || s_in_ready !== e_ready) begin
                miscompares++;
                $display("FAIL mon_in_ready t=%0t got %b/%b want %b", $time, in_ready, s_in_ready, e_ready);
            end
            if (pair_count !== 16'(m_cnt) || s_pair_count !== e_sat) begin
                miscompares++;
                $display("FAIL mon_pair_count t=%0t got %0d/%0d want %0d/%0d", $time, pair_count, s_pair_count, m_cnt, e_sat);
            end
            if (odd_err !== m_odd || s_odd_err !== m_odd) begin
                miscompares++;
                $display("FAIL mon_odd_err t=%0t got %b/%b want %b", $time, odd_err, s_odd_err, m_odd);
            end
            if (flush) begin
                sb.delete();
                m_have_a = 1'b0;
            end else begin
                if (e_valid && out_ready) begin
                    exp_p = sb.pop_front();
                    vectors++;
                    if (out_a !== exp_p.a || out_b !== exp_p.b || s_out_a !== exp_p.a || s_out_b !== exp_p.b) begin
                        miscompares++;
                        $display("FAIL sb_pair t=%0t got a=%h b=%h want a=%h b=%h", $time, out_a, out_b, exp_p.a, exp_p.b);
                    end
                    m_cnt++;
                    delivered++;
                end
                if (in_valid && e_ready) begin
                    if (!m_have_a) begin
                        if (in_last) m_odd = 1'b1;
                        else begin
                            m_have_a = 1'b1;
                            m_a      = in_data;
                        end
                    end else begin
                        sb.push_back('{a: m_a, b: in_data});
                        m_have_a = 1'b0;
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        cycles(2);
        reset_n = 1'b1;
        cycles(1);
    endtask

    // Presents a word until it is accepted; leaves in_valid asserted.
    task automatic send_word(input logic [W-1:0] d, input logic last);
        logic fired = 1'b0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !fired; k++) begin
            @(negedge clock);
            fired = in_ready;
            @(posedge clock);
            #1;
        end
        if (!fired) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout data=%h got no in_ready want accept", d);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_a !== '0 || out_b !== '0 || pair_count !== '0 || odd_err !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_vals got v=%b a=%h b=%h cnt=%0d odd=%b rdy=%b want 0/0/0/0/0/1",
                     out_valid, out_a, out_b, pair_count, odd_err, in_ready);
        end
        do_reset();
    endtask

    task automatic test_basic_pair();
        do_reset();
        out_ready = 1'b1;
        send_word(64'h0, 1'b0);
        send_word(64'hFFFF_FFFF_FFFF_5556, 1'b1);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_a !== 64'h0 || out_b !== 64'hFFFF_FFFF_FFFF_5556) begin
            miscompares++;
            $display("FAIL basic_pair got v=%b a=%h b=%h want 1 0 ffffffffffff5556", out_valid, out_a, out_b);
        end
        cycles(1);
        vectors++;
        if (pair_count !== 16'd1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_count got cnt=%0d v=%b want 1 0", pair_count, out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        send_word(64'hA1, 1'b0);
        send_word(64'hB1, 1'b0);
        in_data = 64'hA2;
        in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_a !== 64'hA1 || out_b !== 64'hB1) begin
                miscompares++;
                $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b a=%h b=%h want 0 1 a1 b1", i, in_ready, out_valid, out_a, out_b);
            end
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        send_word(64'hA2, 1'b0);
        send_word(64'hB2, 1'b1);
        in_valid = 1'b0;
        cycles(2);
        vectors++;
        if (pair_count !== 16'd2 || delivered < 2) begin
            miscompares++;
            $display("FAIL bp_count got %0d want 2", pair_count);
        end
    endtask

    task automatic test_streaming();
        int c0, base;
        do_reset();
        out_ready = 1'b1;
        base = delivered;
        c0   = cyc;
        for (int i = 0; i < 8; i++) send_word(64'h1000 + 64'(i), (i == 7));
        in_valid = 1'b0;
        vectors++;
        if (cyc - c0 !== 8) begin
            miscompares++;
            $display("FAIL stream_rate got %0d cycles want 8", cyc - c0);
        end
        cycles(2);
        vectors++;
        if (pair_count !== 16'd4 || delivered - base !== 4) begin
            miscompares++;
            $display("FAIL stream_count got %0d/%0d want 4", pair_count, delivered - base);
        end
    endtask

    task automatic test_odd_burst();
        do_reset();
        out_ready = 1'b1;
        send_word(64'd1, 1'b0);
        send_word(64'd2, 1'b0);
        send_word(64'd3, 1'b1);
        in_valid = 1'b0;
        cycles(2);
        vectors++;
        if (odd_err !== 1'b1 || pair_count !== 16'd1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL odd_burst got odd=%b cnt=%0d v=%b want 1 1 0", odd_err, pair_count, out_valid);
        end
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        cycles(1);
        vectors++;
        if (odd_err !== 1'b1) begin
            miscompares++;
            $display("FAIL odd_sticky got %b want 1", odd_err);
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b1;
        send_word(64'hDEAD, 1'b0);
        in_data = 64'hBEEF;
        flush   = 1'b1;
        @(negedge clock);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_comb got rdy=%b v=%b want 0 0", in_ready, out_valid);
        end
        @(posedge clock);
        #1;
        flush = 1'b0;
        send_word(64'hC0, 1'b0);
        send_word(64'hD0, 1'b0);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_a !== 64'hC0 || out_b !== 64'hD0) begin
            miscompares++;
            $display("FAIL flush_fresh got v=%b a=%h b=%h want 1 c0 d0", out_valid, out_a, out_b);
        end
        cycles(1);
        vectors++;
        if (pair_count !== 16'd1) begin
            miscompares++;
            $display("FAIL flush_count got %0d want 1", pair_count);
        end
    endtask

    task automatic test_async_reset_sat();
        do_reset();
        out_ready = 1'b1;
        send_word(64'd1, 1'b0);
        send_word(64'd2, 1'b0);
        send_word(64'd3, 1'b1);
        out_ready = 1'b0;
        send_word(64'hAA, 1'b0);
        send_word(64'hBB, 1'b0);
        in_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || pair_count !== '0 || odd_err !== 1'b0 || s_pair_count !== '0) begin
            miscompares++;
            $display("FAIL async_reset got v=%b cnt=%0d odd=%b want 0 0 0", out_valid, pair_count, odd_err);
        end
        cycles(2);
        reset_n = 1'b1;
        cycles(1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_word(64'h500 + 64'(i), 1'b0);
        in_valid = 1'b0;
        cycles(2);
        vectors++;
        if (s_pair_count !== 2'd3 || pair_count !== 16'd5) begin
            miscompares++;
            $display("FAIL saturate got %0d/%0d want 3/5", s_pair_count, pair_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_backpressure();
        test_streaming();
        test_odd_burst();
        test_flush();
        test_async_reset_sat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
